// File: rtl/serial_word_tx_pkg.sv
// Shared types and helpers for the serial word transmitter.
// The optional parity bit is enabled by defining SERIAL_WORD_TX_PARITY_EN.
package serial_word_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } tx_state_e;

    // Level driven on so whenever no frame is in progress.
    localparam logic IDLE_LEVEL = 1'b1;

    // The bit counter must be able to hold W, so it needs clog2(W+1) bits.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_bit_counter.sv
// Bit-position counter for the serial transmitter: clears on a new frame,
// counts while enabled, saturates at MAX and flags the LIMIT position.
module serial_bit_counter
    import serial_word_tx_pkg::*;
#(
    parameter int CW    = 5,
    parameter int LIMIT = 15,
    parameter int MAX   = 16
) (
    input  logic          cl,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] cnt,
    output logic          term
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != CW'(MAX))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge cl or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign term = (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-load, serial-shift transmitter with gapless back-to-back frames.
// Define SERIAL_WORD_TX_PARITY_EN to append an even-parity bit to each frame.
module serial_word_tx
    import serial_word_tx_pkg::*;
#(
    parameter int W         = 16,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic         cl,
    input  logic         rst_n,
    input  logic         st,
    input  logic [W-1:0] d,
    output logic         so,
    output logic         sv,
    output logic         last,
    output logic         busy,
    output logic         done
);

    localparam int CW = cnt_width(W);
`ifdef SERIAL_WORD_TX_PARITY_EN
    localparam int LAST_CNT = W;
`else
    localparam int LAST_CNT = W - 1;
`endif

    tx_state_e     state_q, state_d;
    logic [W-1:0]  shreg_q, shreg_d;
    logic          done_q, done_d;
    logic [CW-1:0] cnt;
    logic          term;
    logic          accept;
    logic          data_end;
`ifdef SERIAL_WORD_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    serial_bit_counter #(
        .CW    (CW),
        .LIMIT (LAST_CNT),
        .MAX   (W)
    ) u_cnt (
        .cl     (cl),
        .rst_n  (rst_n),
        .clear  (accept),
        .enable (state_q != IDLE),
        .cnt    (cnt),
        .term   (term)
    );

    // After an unfollowed frame the counter parks at W, so gate with state too.
    assign busy     = (state_q != IDLE);
    assign sv       = busy;
    assign last     = term && busy;
    assign done     = done_q;
    assign accept   = st && (!busy || last);
    assign data_end = (state_q == SHIFT) && (cnt == CW'(W - 1));

    always_comb begin
        so = IDLE_LEVEL;
        case (state_q)
            SHIFT:   so = LSB_FIRST ? shreg_q[0] : shreg_q[W-1];
`ifdef SERIAL_WORD_TX_PARITY_EN
            PAR:     so = par_q;
`endif
            default: so = IDLE_LEVEL;
        endcase
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        done_d  = last && !accept;
`ifdef SERIAL_WORD_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (accept) begin
            state_d = SHIFT;
            shreg_d = d;
`ifdef SERIAL_WORD_TX_PARITY_EN
            par_d   = ^d;
`endif
        end else begin
            case (state_q)
                SHIFT: begin
                    shreg_d = LSB_FIRST ? {1'b0, shreg_q[W-1:1]}
                                        : {shreg_q[W-2:0], 1'b0};
                    if (data_end) begin
`ifdef SERIAL_WORD_TX_PARITY_EN
                        state_d = PAR;
`else
                        state_d = IDLE;
`endif
                    end
                end
                PAR:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge cl or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            done_q  <= done_d;
        end
    end

`ifdef SERIAL_WORD_TX_PARITY_EN
    always_ff @(posedge cl or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx: an LSB-first and an MSB-first instance
// share inputs; each bit of every frame is compared against the source word.
module tb_serial_word_tx;

`ifdef SERIAL_WORD_TX_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       cl = 1'b0;
    logic       rst_n = 1'b0;
    logic       st = 1'b0;
    logic [7:0] d = 8'h00;
    logic       so_l, sv_l, last_l, busy_l, done_l;
    logic       so_m, sv_m, last_m, busy_m, done_m;
    int         checks = 0;
    int         errors = 0;

    always #5 cl = ~cl;

    serial_word_tx #(.W(8), .LSB_FIRST(1'b1)) u_lsb (
        .cl(cl), .rst_n(rst_n), .st(st), .d(d),
        .so(so_l), .sv(sv_l), .last(last_l), .busy(busy_l), .done(done_l)
    );

    serial_word_tx #(.W(8), .LSB_FIRST(1'b0)) u_msb (
        .cl(cl), .rst_n(rst_n), .st(st), .d(d),
        .so(so_m), .sv(sv_m), .last(last_m), .busy(busy_m), .done(done_m)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic idle_chk(input string tag, input logic exp_done);
        chk({tag, " so_l"}, so_l, 1'b1);
        chk({tag, " so_m"}, so_m, 1'b1);
        chk({tag, " sv_l"}, sv_l, 1'b0);
        chk({tag, " sv_m"}, sv_m, 1'b0);
        chk({tag, " busy_l"}, busy_l, 1'b0);
        chk({tag, " busy_m"}, busy_m, 1'b0);
        chk({tag, " last_l"}, last_l, 1'b0);
        chk({tag, " done_l"}, done_l, exp_done);
        chk({tag, " done_m"}, done_m, exp_done);
    endtask

    // Pulse st for one edge; returns at the negedge showing the first bit.
    task automatic start(input logic [7:0] w);
        st = 1'b1;
        d  = w;
        @(negedge cl);
        st = 1'b0;
        d  = 8'h5A;
    endtask

    // Checks every bit of a frame already started. poke >= 0 raises a stray
    // st (d=3C) during that bit; chain raises st with nxt on the final bit.
    task automatic run_frame(input logic [7:0] w, input bit chain,
                             input logic [7:0] nxt, input int poke);
        logic exp_l, exp_m;
        string t;
        for (int i = 0; i < FL; i++) begin
            if (i > 0) @(negedge cl);
            if (i == poke + 1) begin
                st = 1'b0;
                d  = 8'h5A;
            end
            exp_l = (i < 8) ? w[i]     : ^w;
            exp_m = (i < 8) ? w[7 - i] : ^w;
            t = $sformatf("w=%h bit%0d", w, i);
            chk({t, " so_l"}, so_l, exp_l);
            chk({t, " so_m"}, so_m, exp_m);
            chk({t, " sv_l"}, sv_l, 1'b1);
            chk({t, " busy_m"}, busy_m, 1'b1);
            chk({t, " last_l"}, last_l, (i == FL - 1));
            chk({t, " last_m"}, last_m, (i == FL - 1));
            chk({t, " done_l"}, done_l, 1'b0);
            if (i == poke) begin
                st = 1'b1;
                d  = 8'h3C;
            end
        end
        if (chain) begin
            st = 1'b1;
            d  = nxt;
            @(negedge cl);
            st = 1'b0;
            d  = 8'h5A;
        end else begin
            @(negedge cl);
            idle_chk($sformatf("w=%h tail", w), 1'b1);
            @(negedge cl);
            idle_chk($sformatf("w=%h tail+1", w), 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        idle_chk("reset", 1'b0);
        @(negedge cl);
        rst_n = 1'b1;
        @(negedge cl);
        idle_chk("idle", 1'b0);

        // Single frames: palindrome and an asymmetric word.
        start(8'hA5);
        run_frame(8'hA5, 1'b0, 8'h00, -1);
        start(8'h01);
        run_frame(8'h01, 1'b0, 8'h00, -1);

        // Gapless back-to-back: no done between words.
        start(8'hFF);
        run_frame(8'hFF, 1'b1, 8'h00, -1);
        chk("b2b done_l", done_l, 1'b0);
        chk("b2b done_m", done_m, 1'b0);
        run_frame(8'h00, 1'b0, 8'h00, -1);

        // Stray st mid-frame is ignored.
        start(8'hA5);
        run_frame(8'hA5, 1'b0, 8'h00, 2);

        // Asynchronous reset mid-frame takes effect before the next edge.
        start(8'hC3);
        repeat (3) @(negedge cl);
        #1 rst_n = 1'b0;
        #1;
        idle_chk("async_rst", 1'b0);
        @(negedge cl);
        rst_n = 1'b1;
        @(negedge cl);
        idle_chk("post_rst", 1'b0);
        start(8'hC3);
        run_frame(8'hC3, 1'b0, 8'h00, -1);

        // Odd and even parity words (parity cycle only in the parity build).
        start(8'h07);
        run_frame(8'h07, 1'b0, 8'h00, -1);
        start(8'h03);
        run_frame(8'h03, 1'b0, 8'h00, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_word_tx.md
Name: serial_word_tx

Overview:
- Parallel-load, serial-shift transmitter. Captures a W-bit word on a store strobe and shifts it out one bit per clock.
- Transmit-side counterpart to the DFF-based storage and capture elements; feeds a downstream serial capture register.
- Supports gapless back-to-back words and an optional trailing parity bit.

Parameters:
- W, 16, data word width in bits (W >= 2).
- LSB_FIRST, 1, 1 = bit 0 is sent first; 0 = bit W-1 is sent first.

Ports:
- cl, input, 1, clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- st, input, 1, store/start strobe; word on d is accepted when the acceptance rule below holds.
- d, input, W, parallel data word.
- so, output, 1, serial data out.
- sv, output, 1, so carries a valid bit this cycle.
- last, output, 1, current so bit is the final bit of the frame.
- busy, output, 1, frame in progress.
- done, output, 1, one-cycle pulse on the cycle after a frame's final bit when no new frame follows.

Behaviour:
- Reset (async, any time including mid-frame): state=IDLE, shreg=0, cnt=0, so=1, sv=0, last=0, busy=0, done=0. A partially sent frame is abandoned, not resumed.
- Acceptance rule: accept = st & (~busy | last). An st that does not satisfy the rule is ignored; no latching, no queuing.
- On accept at edge k:
  - shreg <= d; cnt <= 0; state <= SHIFT.
  - First bit appears on so with sv=1 in the cycle after edge k (one-cycle latency).
- SHIFT:
  - Each edge advances one bit: shift right if LSB_FIRST=1, shift left if LSB_FIRST=0; cnt increments.
  - so = shreg[0] or shreg[W-1], chosen by LSB_FIRST.
  - last=1 when cnt==W-1 and parity is disabled.
- End of frame:
  - last && accept → next word starts immediately; no idle gap, no done pulse.
  - last && ~accept → IDLE; done=1 for exactly one cycle.
- IDLE: so=1, sv=0, busy=0, last=0.
- Outputs so, sv, last and busy are registered or decoded from registered state only; no combinational path from st or d to any output.
- cnt width is clog2(W+1); it never exceeds W; it wraps to 0 only on accept.

Optional Feature:
- Macro: SERIAL_WORD_TX_PARITY_EN.
- Defined:
  - Adds a PAR state after bit W-1; last moves from bit W-1 to the PAR cycle.
  - so = even parity (XOR) of the accepted word, sv=1 during PAR.
  - Parity is computed from d at accept and held in a dedicated register.
  - Frame length is W+1 cycles.
- Undefined: no PAR state and no parity register; frame length is W cycles.

Decomposition:
- Shared package serial_word_tx_pkg:
  - state enum IDLE / SHIFT / PAR (2-bit encoding).
  - function for counter width, clog2(W+1).
  - localparam IDLE_LEVEL = 1'b1.
- One sub-module, serial_bit_counter:
  - Inputs: clear, enable. Output: terminal flag at a programmable limit (W-1 or W).
  - Reset async active-low, like the parent.

Test Plan:
- W=8, LSB_FIRST=1, d=8'hA5, st pulse at cycle 2 → so=1,0,1,0,0,1,0,1 with sv=1 in cycles 3-10; last in cycle 10; done in cycle 11; busy 3-10.
- LSB_FIRST=0, d=8'hA5 → so=1,0,1,0,0,1,0,1 MSB-first in the same cycles (the pattern is a palindrome); repeat with 8'h01 → seven 0s then a 1.
- Back-to-back: st with 8'hFF, then st with 8'h00 held high during the last cycle → sixteen consecutive sv=1 cycles, eight 1s then eight 0s; no done between words, done after the second word only.
- st pulsed mid-frame (cycle 5) with d=8'h3C → ignored; the original word completes unchanged.
- rst_n low at cycle 6 of a frame → so=1, sv=0, busy=0 immediately (before the next edge); the next st sends a full fresh frame.
- With SERIAL_WORD_TX_PARITY_EN, d=8'h07 → 8 data bits, then so=1 with last=1 in a 9th cycle; d=8'h03 → parity bit 0.
